// File: rtl/mem_port.sv
// mem_port: memory-access stage of the multi-cycle RISC-V core (request/ack bus, IR/OldPC/Data).
// Optional sub-word (byte/halfword) data accesses are enabled by defining MEM_PORT_SUBWORD_EN.
module mem_port #(
  parameter logic [31:0] RESET_IR       = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] pc_i,
  input  logic [2:0]  funct3_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        ir_write_i,
  output logic        stall_o,
  output logic [31:0] instr_o,
  output logic [31:0] old_pc_o,
  output logic [31:0] data_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        req, is_fetch, misaligned, timeout;
  logic [7:0]  cnt;
  logic [31:0] fetch_pc;
  logic        acc_fetch, acc_write;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt, load_val;

  assign req      = mem_read_i | mem_write_i;
  assign is_fetch = ir_write_i & ~mem_write_i;
  assign stall_o  = req & (state != DONE) & ~rst;
  assign timeout  = (cnt == TIMEOUT_LAST);

`ifdef MEM_PORT_SUBWORD_EN
  logic [2:0] acc_funct3;
  logic [1:0] acc_off;
  logic [31:0] lane;

  // Fetches are always full words; data accesses take their size from funct3.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    be_nxt     = 4'hF;
    wdata_nxt  = wdata_i;
    misaligned = |adr_i[1:0];
    if (!is_fetch) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_nxt     = 4'b0001 << adr_i[1:0];
          wdata_nxt  = {4{wdata_i[7:0]}};
          misaligned = 1'b0;
        end
        2'b01: begin
          be_nxt     = 4'b0011 << adr_i[1:0];
          wdata_nxt  = {2{wdata_i[15:0]}};
          misaligned = adr_i[0];
        end
        default: ;
      endcase
    end
  end

  assign lane = bus_rdata_i >> {acc_off, 3'b000};

  always_comb begin
    case (acc_funct3)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'h0, lane[7:0]};
      3'b101:  load_val = {16'h0, lane[15:0]};
      default: load_val = bus_rdata_i;
    endcase
  end
`else
  logic unused_funct3;

  assign be_nxt        = 4'hF;
  assign wdata_nxt     = wdata_i;
  assign misaligned    = |adr_i[1:0];
  assign load_val      = bus_rdata_i;
  assign unused_funct3 = ^funct3_i;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = misaligned ? DONE : BUSY;
      BUSY:    if (bus_ack_i || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_o     <= RESET_IR;
      old_pc_o    <= '0;
      data_o      <= '0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_be_o    <= '0;
      cnt         <= '0;
      fetch_pc    <= '0;
      acc_fetch   <= 1'b0;
      acc_write   <= 1'b0;
`ifdef MEM_PORT_SUBWORD_EN
      acc_funct3  <= '0;
      acc_off     <= '0;
`endif
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (req && misaligned) begin
            misalign_o <= 1'b1;
          end else if (req) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_write_i;
            bus_addr_o  <= {adr_i[31:2], 2'b00};
            bus_wdata_o <= wdata_nxt;
            bus_be_o    <= be_nxt;
            cnt         <= '0;
            fetch_pc    <= pc_i;
            acc_fetch   <= is_fetch;
            acc_write   <= mem_write_i;
`ifdef MEM_PORT_SUBWORD_EN
            acc_funct3  <= funct3_i;
            acc_off     <= adr_i[1:0];
`endif
          end
        end
        BUSY: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            if (!acc_write && acc_fetch) begin
              instr_o  <= bus_rdata_i;
              old_pc_o <= fetch_pc;
            end else if (!acc_write) begin
              data_o <= load_val;
            end
          end else begin
            cnt <= cnt + 8'd1;
            // Abandon the access; a late ack will land in DONE/IDLE and be ignored.
            if (timeout) begin
              bus_req_o <= 1'b0;
              bus_we_o  <= 1'b0;
              bus_err_o <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: a bus responder with configurable ack latency plus a
// scoreboard queue of expected per-access results.
`timescale 1ns/1ps
module tb_mem_port;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr_i = '0, wdata_i = '0, pc_i = '0, bus_rdata_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0, ir_write_i = 1'b0, bus_ack_i = 1'b0;
  logic        stall_o, misalign_o, bus_err_o, bus_req_o, bus_we_o;
  logic [31:0] instr_o, old_pc_o, data_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;

  mem_port #(.RESET_IR(32'h0000_0013), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .adr_i(adr_i), .wdata_i(wdata_i), .pc_i(pc_i),
    .funct3_i(funct3_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .ir_write_i(ir_write_i), .stall_o(stall_o), .instr_o(instr_o), .old_pc_o(old_pc_o),
    .data_o(data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_be_o(bus_be_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, wdata, instr, old_pc, data;
    logic        we, stall0, mis, err;
    logic [3:0]  be;
    int          req_cycles, done_cycle;
  } acc_t;

  typedef struct {
    logic [31:0] adr, rdata;
    int          delay;
  } stim_t;

  acc_t        sb[$];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] exp_instr, exp_old_pc, exp_data;

  // Drives one access from an IDLE negedge, acks 'delay' cycles after bus_req_o rises
  // (delay < 0: never), records what the DUT did, and returns at the next IDLE negedge.
  task automatic run_access(input logic rd, input logic wr, input logic irw,
                            input logic [2:0] f3, input logic [31:0] adr,
                            input logic [31:0] wdata, input logic [31:0] pc,
                            input logic [31:0] rdata, input int delay, output acc_t o);
    int req_k;
    bit done;
    o = '{default: 0};
    o.done_cycle = -1;
    req_k = -1;
    done = 0;
    mem_read_i = rd; mem_write_i = wr; ir_write_i = irw; funct3_i = f3;
    adr_i = adr; wdata_i = wdata; pc_i = pc;
    for (int k = 0; k < 300 && !done; k++) begin
      #1;
      if (k == 0) o.stall0 = stall_o;
      if (k == 1) begin
        adr_i = ~adr; wdata_i = ~wdata; pc_i = ~pc; funct3_i = ~f3;
      end
      if (bus_req_o === 1'b1) begin
        if (req_k < 0) begin
          req_k = k;
          o.addr = bus_addr_o; o.we = bus_we_o; o.be = bus_be_o; o.wdata = bus_wdata_o;
        end
        o.req_cycles++;
      end
      if (k > 0 && stall_o === 1'b0) begin
        o.done_cycle = k; o.mis = misalign_o; o.err = bus_err_o;
        o.instr = instr_o; o.old_pc = old_pc_o; o.data = data_o;
        done = 1;
      end else begin
        bus_ack_i   = (req_k >= 0 && delay >= 0 && k == req_k + delay);
        bus_rdata_i = bus_ack_i ? rdata : ~rdata;
        @(negedge clk);
      end
    end
    mem_read_i = 1'b0; mem_write_i = 1'b0; ir_write_i = 1'b0; bus_ack_i = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL access_timeout: stall_o never released, want release within 300 cycles");
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (instr_o !== 32'h13) begin n_bad++; $display("FAIL reset_instr: got %h want 00000013", instr_o); end
    n_cmp++; if ({old_pc_o, data_o} !== 64'h0) begin n_bad++; $display("FAIL reset_regs: got old_pc %h data %h want 0", old_pc_o, data_o); end
    n_cmp++; if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} !== '0) begin
      n_bad++; $display("FAIL reset_bus: got req %b we %b addr %h wdata %h be %h want all 0", bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o); end
    n_cmp++; if ({misalign_o, bus_err_o, stall_o} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {misalign_o, bus_err_o, stall_o}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_instr = 32'h13; exp_old_pc = '0; exp_data = '0;
  endtask

  task automatic test_fetch();
    acc_t e, o;
    e = '{default: 0};
    e.addr = 32'h10; e.we = 1'b0; e.be = 4'hF; e.stall0 = 1'b1; e.req_cycles = 3; e.done_cycle = 4;
    e.instr = 32'h00A0_0093; e.old_pc = 32'h10; e.data = exp_data;
    sb.push_back(e);
    run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'h10, 32'h00A0_0093, 2, o);
    e = sb.pop_front();
    n_cmp++; if (o.stall0 !== e.stall0) begin n_bad++; $display("FAIL fetch_stall0: got %b want %b", o.stall0, e.stall0); end
    n_cmp++; if ({o.addr, o.we, o.be} !== {e.addr, e.we, e.be}) begin n_bad++; $display("FAIL fetch_bus: got addr %h we %b be %h want %h %b %h", o.addr, o.we, o.be, e.addr, e.we, e.be); end
    n_cmp++; if (o.req_cycles != e.req_cycles) begin n_bad++; $display("FAIL fetch_req_len: got %0d want %0d", o.req_cycles, e.req_cycles); end
    n_cmp++; if (o.done_cycle != e.done_cycle) begin n_bad++; $display("FAIL fetch_done_cycle: got %0d want %0d", o.done_cycle, e.done_cycle); end
    n_cmp++; if ({o.instr, o.old_pc, o.data} !== {e.instr, e.old_pc, e.data}) begin
      n_bad++; $display("FAIL fetch_regs: got ir %h oldpc %h data %h want %h %h %h", o.instr, o.old_pc, o.data, e.instr, e.old_pc, e.data); end
    exp_instr = e.instr; exp_old_pc = e.old_pc;
  endtask

  task automatic test_store_load();
    acc_t e, o;
    e = '{default: 0};
    e.addr = 32'h100; e.we = 1'b1; e.be = 4'hF; e.wdata = 32'hDEAD_BEEF; e.done_cycle = 2;
    e.instr = exp_instr; e.data = exp_data;
    sb.push_back(e);
    run_access(1'b0, 1'b1, 1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h14, 32'hCAFE_F00D, 0, o);
    e = sb.pop_front();
    n_cmp++; if ({o.addr, o.we, o.be, o.wdata} !== {e.addr, e.we, e.be, e.wdata}) begin
      n_bad++; $display("FAIL sw_bus: got addr %h we %b be %h wdata %h want %h %b %h %h", o.addr, o.we, o.be, o.wdata, e.addr, e.we, e.be, e.wdata); end
    n_cmp++; if (o.done_cycle != e.done_cycle) begin n_bad++; $display("FAIL sw_done_cycle: got %0d want %0d", o.done_cycle, e.done_cycle); end
    n_cmp++; if ({o.instr, o.data} !== {e.instr, e.data}) begin n_bad++; $display("FAIL sw_regs: got ir %h data %h want %h %h", o.instr, o.data, e.instr, e.data); end

    e = '{default: 0};
    e.addr = 32'h104; e.we = 1'b0; e.done_cycle = 3; e.data = 32'h1122_3344;
    sb.push_back(e);
    run_access(1'b1, 1'b0, 1'b0, 3'b010, 32'h104, 32'h0, 32'h18, 32'h1122_3344, 1, o);
    e = sb.pop_front();
    n_cmp++; if ({o.addr, o.we} !== {e.addr, e.we}) begin n_bad++; $display("FAIL lw_bus: got addr %h we %b want %h %b", o.addr, o.we, e.addr, e.we); end
    n_cmp++; if (o.done_cycle != e.done_cycle) begin n_bad++; $display("FAIL lw_done_cycle: got %0d want %0d", o.done_cycle, e.done_cycle); end
    n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL lw_data: got %h want %h", o.data, e.data); end
    exp_data = e.data;
  endtask

  task automatic test_misalign();
    acc_t e, o;
    e = '{default: 0};
    e.mis = 1'b1; e.done_cycle = 1; e.req_cycles = 0; e.data = exp_data;
    sb.push_back(e);
    run_access(1'b1, 1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 32'h1C, 32'h5555_5555, 0, o);
    e = sb.pop_front();
    n_cmp++; if ({o.mis, o.req_cycles, o.done_cycle} !== {e.mis, e.req_cycles, e.done_cycle}) begin
      n_bad++; $display("FAIL lw_misalign: got mis %b req %0d done %0d want %b %0d %0d", o.mis, o.req_cycles, o.done_cycle, e.mis, e.req_cycles, e.done_cycle); end
    n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL lw_misalign_data: got %h want %h", o.data, e.data); end

    e = '{default: 0};
    e.mis = 1'b1; e.done_cycle = 1; e.instr = exp_instr; e.old_pc = exp_old_pc;
    sb.push_back(e);
    run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h12, 32'h0, 32'h12, 32'h0000_0000, 0, o);
    e = sb.pop_front();
    n_cmp++; if ({o.mis, o.req_cycles, o.done_cycle} !== {e.mis, e.req_cycles, e.done_cycle}) begin
      n_bad++; $display("FAIL fetch_misalign: got mis %b req %0d done %0d want %b %0d %0d", o.mis, o.req_cycles, o.done_cycle, e.mis, e.req_cycles, e.done_cycle); end
    n_cmp++; if ({o.instr, o.old_pc} !== {e.instr, e.old_pc}) begin n_bad++; $display("FAIL fetch_misalign_regs: got %h %h want %h %h", o.instr, o.old_pc, e.instr, e.old_pc); end
  endtask

  task automatic test_subword();
    acc_t e, o;
`ifdef MEM_PORT_SUBWORD_EN
    // {rd, wr, funct3, adr, wdata, rdata, expect misaligned, be, wdata on bus, data_o}
    logic [31:0] t_adr[7]   = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h101, 32'h102};
    logic [2:0]  t_f3[7]    = '{3'b000, 3'b100, 3'b001, 3'b001, 3'b001, 3'b000, 3'b011};
    logic        t_wr[7]    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_wd[7]    = '{32'h0, 32'h0, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_00AB, 32'h0};
    logic [31:0] t_rd[7]    = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h0, 32'h8001_5555, 32'h0, 32'h0, 32'h0};
    logic        t_mis[7]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  t_be[7]    = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'h0, 4'b0010, 4'h0};
    logic [31:0] t_bwd[7]   = '{32'h0, 32'h0, 32'h1234_1234, 32'h0, 32'h0, 32'hABAB_ABAB, 32'h0};
    logic [31:0] t_data[7]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0, 32'hFFFF_8001, 32'h0, 32'h0, 32'h0};
    int n = 7;
`else
    logic [31:0] t_adr[4]   = '{32'h103, 32'h102, 32'h100, 32'h100};
    logic [2:0]  t_f3[4]    = '{3'b000, 3'b001, 3'b001, 3'b000};
    logic        t_wr[4]    = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_wd[4]    = '{32'h0, 32'h0000_1234, 32'h0000_1234, 32'h0};
    logic [31:0] t_rd[4]    = '{32'h0, 32'h0, 32'h0, 32'h80FF_FFFF};
    logic        t_mis[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  t_be[4]    = '{4'h0, 4'h0, 4'hF, 4'hF};
    logic [31:0] t_bwd[4]   = '{32'h0, 32'h0, 32'h0000_1234, 32'h0};
    logic [31:0] t_data[4]  = '{32'h0, 32'h0, 32'h0, 32'h80FF_FFFF};
    int n = 4;
`endif
    for (int i = 0; i < n; i++) begin
      e = '{default: 0};
      e.mis = t_mis[i];
      e.done_cycle = t_mis[i] ? 1 : 2;
      e.be = t_be[i];
      e.wdata = t_bwd[i];
      e.data = (t_mis[i] || t_wr[i]) ? exp_data : t_data[i];
      sb.push_back(e);
      run_access(~t_wr[i], t_wr[i], 1'b0, t_f3[i], t_adr[i], t_wd[i], 32'h20, t_rd[i], 0, o);
      e = sb.pop_front();
      n_cmp++; if ({o.mis, o.done_cycle} !== {e.mis, e.done_cycle}) begin
        n_bad++; $display("FAIL sub%0d_timing: got mis %b done %0d want %b %0d", i, o.mis, o.done_cycle, e.mis, e.done_cycle); end
      if (!e.mis) begin
        n_cmp++; if (o.be !== e.be) begin n_bad++; $display("FAIL sub%0d_be: got %b want %b", i, o.be, e.be); end
      end
      if (!e.mis && t_wr[i]) begin
        n_cmp++; if (o.wdata !== e.wdata) begin n_bad++; $display("FAIL sub%0d_wdata: got %h want %h", i, o.wdata, e.wdata); end
      end
      n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL sub%0d_data: got %h want %h", i, o.data, e.data); end
      exp_data = e.data;
    end
  endtask

  task automatic test_timeout();
    acc_t e, o;
    e = '{default: 0};
    e.err = 1'b1; e.req_cycles = TMO; e.done_cycle = TMO + 1; e.instr = exp_instr; e.old_pc = exp_old_pc;
    sb.push_back(e);
    run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 32'h20, 32'h1111_1111, -1, o);
    e = sb.pop_front();
    n_cmp++; if ({o.err, o.mis} !== {e.err, 1'b0}) begin n_bad++; $display("FAIL tmo_err: got err %b mis %b want 1 0", o.err, o.mis); end
    n_cmp++; if (o.req_cycles != e.req_cycles || o.done_cycle != e.done_cycle) begin
      n_bad++; $display("FAIL tmo_timing: got req %0d done %0d want %0d %0d", o.req_cycles, o.done_cycle, e.req_cycles, e.done_cycle); end
    n_cmp++; if ({o.instr, o.old_pc} !== {e.instr, e.old_pc}) begin n_bad++; $display("FAIL tmo_regs: got %h %h want %h %h", o.instr, o.old_pc, e.instr, e.old_pc); end
    #1;
    n_cmp++; if ({bus_req_o, bus_err_o, stall_o} !== 3'b000) begin n_bad++; $display("FAIL tmo_idle: got req/err/stall %b want 000", {bus_req_o, bus_err_o, stall_o}); end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    stim_t s;
    acc_t e, o;
    for (int i = 0; i < 6; i++) begin
      s.adr = 32'h200 + 32'(4 * i);
      s.rdata = $urandom;
      s.delay = $urandom_range(0, 3);
      st.push_back(s);
      e = '{default: 0};
      e.instr = s.rdata; e.old_pc = s.adr; e.done_cycle = 2 + s.delay; e.req_cycles = 1 + s.delay;
      sb.push_back(e);
    end
    while (st.size() > 0) begin
      s = st.pop_front();
      run_access(1'b1, 1'b0, 1'b1, 3'b010, s.adr, 32'h0, s.adr, s.rdata, s.delay, o);
      e = sb.pop_front();
      n_cmp++; if ({o.instr, o.old_pc} !== {e.instr, e.old_pc}) begin
        n_bad++; $display("FAIL b2b_regs@%h: got ir %h oldpc %h want %h %h", s.adr, o.instr, o.old_pc, e.instr, e.old_pc); end
      n_cmp++; if (o.done_cycle != e.done_cycle || o.req_cycles != e.req_cycles) begin
        n_bad++; $display("FAIL b2b_timing@%h: got done %0d req %0d want %0d %0d", s.adr, o.done_cycle, o.req_cycles, e.done_cycle, e.req_cycles); end
      exp_instr = e.instr; exp_old_pc = e.old_pc;
    end
  endtask

  task automatic test_reset_busy();
    mem_read_i = 1'b1; ir_write_i = 1'b1; adr_i = 32'h40; pc_i = 32'h40;
    @(negedge clk);
    #1;
    n_cmp++; if (bus_req_o !== 1'b1) begin n_bad++; $display("FAIL rstbusy_req: got %b want 1", bus_req_o); end
    rst = 1'b1;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL rstbusy_stall: got %b want 0", stall_o); end
    @(negedge clk);
    rst = 1'b0; mem_read_i = 1'b0; ir_write_i = 1'b0;
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if ({bus_req_o, stall_o} !== 2'b00) begin n_bad++; $display("FAIL rstbusy_idle: got req/stall %b want 00", {bus_req_o, stall_o}); end
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    n_cmp++; if ({instr_o, old_pc_o, data_o} !== {32'h13, 32'h0, 32'h0}) begin
      n_bad++; $display("FAIL rstbusy_regs: got ir %h oldpc %h data %h want 00000013 0 0", instr_o, old_pc_o, data_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_misalign();
    test_subword();
    test_timeout();
    test_back_to_back();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
